sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock FIFO, parametrised in data width, depth and read mode. Successor to the fixed 8-bit x 16 FIFO, keeping its put/get/fillcount/empty/full interface. Adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. Used as the generic buffering element between producer and consumer blocks in one clock domain.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
AFULL_TH, 12, almost_full asserts when fillcount >= AFULL_TH (legal range 1..DEPTH)
AEMPTY_TH, 2, almost_empty asserts when fillcount <= AEMPTY_TH (legal range 0..DEPTH-1)
FWFT, 0, 0 = registered read (standard mode); 1 = first-word-fall-through

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_W  write data
put  input  1  write request
get  input  1  read request
clr_err  input  1  synchronous clear of overflow/underflow
data_out  output  DATA_W  read data
fillcount  output  ADDR_W+1  number of stored entries, 0..DEPTH
empty  output  1  fillcount == 0
full  output  1  fillcount == DEPTH
almost_full  output  1  fillcount >= AFULL_TH
almost_empty  output  1  fillcount <= AEMPTY_TH
overflow  output  1  sticky: a put was rejected
underflow  output  1  sticky: a get was rejected

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation): read/write pointers = 0, fillcount = 0, overflow = underflow = 0, data_out = 0, contents discarded. Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0. Memory array need not be reset.
- Read accept: rd_ok = get && !empty.
- Write accept: wr_ok = put && (!full || rd_ok). When full, a simultaneous accepted read frees the slot in the same cycle.
- When empty with put and get both high: write accepted, read rejected, underflow set.
- Write: on the edge with wr_ok, mem[wr_ptr] <= data_in and wr_ptr increments mod DEPTH.
- Read: on the edge with rd_ok, rd_ptr increments mod DEPTH.
- fillcount update: +1 if only wr_ok, -1 if only rd_ok, unchanged if both or neither. It never exceeds DEPTH and never goes below 0.
- Flags: empty, full, almost_full and almost_empty are decoded from the registered fillcount, so they change in the cycle after the causing edge. There is no combinational path from put/get to the flags.
- Errors: overflow <= 1 on an edge with put && !wr_ok; underflow <= 1 on an edge with get && !rd_ok. Both are sticky until clr_err is sampled high. If clr_err and a new error occur on the same edge, the flag is set (set wins).
- FWFT=0: on an rd_ok edge, data_out <= mem[rd_ptr]. Latency is 1 clock from the get edge. data_out holds its value otherwise, including on rejected reads.
- FWFT=1: data_out = empty ? 0 : mem[rd_ptr], combinational from registered state.
  - The head entry is visible without a get.
  - A word written into an empty FIFO appears on data_out in the cycle after the write edge.
  - get pops the head, and data_out shows the next entry after that edge.
- Pointer wrap is implicit via ADDR_W-bit counters.
- Parameter check: ADDR_W >= 1 and thresholds within their legal ranges are enforced by an elaboration-time check.

Test Plan:
1. (Defaults) Reset, then 16 put cycles with data 0x01..0x10 -> fillcount counts 1..16; almost_empty drops after the 3rd write; almost_full rises once fillcount reaches 12; full = 1 after the 16th edge.
2. With full = 1, put = 1 and get = 0 for one cycle, data 0x11 -> write dropped, fillcount stays 16, overflow = 1. Then 16 get cycles -> data_out = 0x01..0x10 in order, one clock after each get edge; ends with empty = 1 and fillcount = 0.
3. On empty, get for 1 cycle -> underflow = 1, data_out holds 0x10. Pulse clr_err -> both error flags 0 on the next edge. Drive clr_err together with a rejected get -> underflow stays 1.
4. Simultaneous put+get:
   - At full (count 16): count stays 16, overflow stays 0, oldest word read out.
   - At empty: count becomes 1, underflow = 1.
   - At count 5: count stays 5.
5. Wrap: 40 writes and 40 reads of an incrementing pattern, with fillcount kept between 3 and 10 -> every word is read back in order across multiple pointer wraps; no error flags set.
6. FWFT=1, then reset mid-operation:
   - Write 0xA5 to empty -> data_out = 0xA5 and empty = 0 one cycle later with no get.
   - Write 0x5A, then one get -> data_out = 0x5A.
   - With fillcount = 7, assert reset between clock edges -> fillcount = 0, empty = 1, data_out = 0 immediately, before the next edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth, threshold flags, sticky error flags
// and optional first-word-fall-through read mode.
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              put,
   input  logic              get,
   input  logic              clr_err,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W:0]   fillcount,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W + 1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W + 1)'(AEMPTY_TH);
   localparam logic [ADDR_W:0] CNT_ONE_C = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1);

   generate
      if (ADDR_W < 1 || AFULL_TH < 1 || AFULL_TH > DEPTH ||
          AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_param_err
         $error("sync_fifo_param: illegal ADDR_W or threshold parameter");
      end
   endgenerate

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   fill_q, fill_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              rd_ok_s;
   logic              wr_ok_s;

   // Accept decisions: a read at full frees the slot for a same-cycle write.
   always_comb begin
      rd_ok_s = get && !empty_q;
      wr_ok_s = put && (!full_q || rd_ok_s);
   end

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (wr_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
         2'b10:   fill_d = fill_q + CNT_ONE_C;
         2'b01:   fill_d = fill_q - CNT_ONE_C;
         default: fill_d = fill_q;
      endcase
   end

   // Status flags are decoded from the next occupancy so they register alongside it.
   always_comb begin
      empty_d  = (fill_d == '0);
      full_d   = (fill_d == DEPTH_C);
      afull_d  = (fill_d >= AFULL_C);
      aempty_d = (fill_d <= AEMPTY_C);
   end

   // Sticky error flags; a new error on the clearing edge wins.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (put && !wr_ok_s) begin
         ovf_d = 1'b1;
      end else if (clr_err) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if (get && !rd_ok_s) begin
         unf_d = 1'b1;
      end else if (clr_err) begin
         unf_d = 1'b0;
      end else begin
         unf_d = unf_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array, deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry is presented straight from registered state.
         always_comb begin
            if (empty_q) begin
               data_out = '0;
            end else begin
               data_out = mem_q[rd_ptr_q];
            end
         end
      end else begin : g_std
         logic [DATA_W-1:0] dout_q;

         // Registered read port: updates only on an accepted read.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               dout_q <= '0;
            end else if (rd_ok_s) begin
               dout_q <= mem_q[rd_ptr_q];
            end else begin
               dout_q <= dout_q;
            end
         end

         assign data_out = dout_q;
      end
   endgenerate

   assign fillcount    = fill_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-mode instance checked against a queue
// scoreboard, plus a first-word-fall-through instance with a mid-cycle reset.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic [7:0] din0, din1, dout0, dout1;
   logic       put0, get0, clr0, put1, get1, clr1;
   logic [4:0] fc0, fc1;
   logic       emp0, ful0, af0, ae0, ovf0, unf0;
   logic       emp1, ful1, af1, ae1, ovf1, unf1;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   sync_fifo_param #(.FWFT(0)) u_dut0 (
      .clk(clk), .reset(rst0), .data_in(din0), .put(put0), .get(get0), .clr_err(clr0),
      .data_out(dout0), .fillcount(fc0), .empty(emp0), .full(ful0),
      .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0));

   sync_fifo_param #(.FWFT(1)) u_dut1 (
      .clk(clk), .reset(rst1), .data_in(din1), .put(put1), .get(get1), .clr_err(clr1),
      .data_out(dout1), .fillcount(fc1), .empty(emp1), .full(ful1),
      .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] sb_pop();
      if (sb_q.size() == 0) return 8'hxx;
      return sb_q.pop_front();
   endfunction

   task automatic drain0(input int n, input string tag);
      get0 = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, 32'(dout0), 32'(sb_pop()));
      end
      get0 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, nw, nr, cyc;
      logic p, g;
      rst0 = 1'b1; rst1 = 1'b1;
      {din0, put0, get0, clr0} = '0;
      {din1, put1, get1, clr1} = '0;
      tick(); tick();
      chk("rst_fill", 32'(fc0), 32'd0);
      chk("rst_empty", 32'(emp0), 32'd1);
      chk("rst_full", 32'(ful0), 32'd0);
      chk("rst_ae", 32'(ae0), 32'd1);
      chk("rst_af", 32'(af0), 32'd0);
      chk("rst_err", 32'({ovf0, unf0}), 32'd0);
      chk("rst_dout", 32'(dout0), 32'd0);
      rst0 = 1'b0;

      // 1: fill with 0x01..0x10
      put0 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         din0 = 8'(i);
         sb_q.push_back(8'(i));
         tick();
         chk("t1_fill", 32'(fc0), 32'(i));
         chk("t1_ae", 32'(ae0), 32'(i <= 2));
         chk("t1_af", 32'(af0), 32'(i >= 12));
         chk("t1_full", 32'(ful0), 32'(i == 16));
         chk("t1_empty", 32'(emp0), 32'd0);
      end

      // 2: overflow then drain in order
      din0 = 8'h11;
      tick();
      put0 = 1'b0;
      chk("t2_fill", 32'(fc0), 32'd16);
      chk("t2_ovf", 32'(ovf0), 32'd1);
      drain0(16, "t2_data");
      chk("t2_empty", 32'(emp0), 32'd1);
      chk("t2_fill0", 32'(fc0), 32'd0);
      chk("t2_ovf_sticky", 32'(ovf0), 32'd1);

      // 3: underflow, clear, set-wins
      get0 = 1'b1;
      tick();
      get0 = 1'b0;
      chk("t3_unf", 32'(unf0), 32'd1);
      chk("t3_hold", 32'(dout0), 32'h10);
      clr0 = 1'b1;
      tick();
      chk("t3_clr", 32'({ovf0, unf0}), 32'd0);
      get0 = 1'b1;
      tick();
      get0 = 1'b0;
      chk("t3_setwins", 32'(unf0), 32'd1);
      tick();
      clr0 = 1'b0;
      chk("t3_clr2", 32'(unf0), 32'd0);

      // 4: simultaneous put+get at full, empty, and count 5
      put0 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din0 = 8'(8'h20 + i);
         sb_q.push_back(din0);
         tick();
      end
      chk("t4_full", 32'(ful0), 32'd1);
      get0 = 1'b1; din0 = 8'h99;
      tick();
      put0 = 1'b0; get0 = 1'b0;
      chk("t4_full_fill", 32'(fc0), 32'd16);
      chk("t4_full_ovf", 32'(ovf0), 32'd0);
      chk("t4_full_data", 32'(dout0), 32'(sb_pop()));
      sb_q.push_back(8'h99);
      drain0(16, "t4_drain");
      put0 = 1'b1; get0 = 1'b1; din0 = 8'h77;
      sb_q.push_back(8'h77);
      tick();
      get0 = 1'b0;
      chk("t4_empty_fill", 32'(fc0), 32'd1);
      chk("t4_empty_unf", 32'(unf0), 32'd1);
      for (int i = 0; i < 4; i++) begin
         din0 = 8'(8'h70 + i);
         sb_q.push_back(din0);
         tick();
      end
      chk("t4_fill5", 32'(fc0), 32'd5);
      get0 = 1'b1; din0 = 8'h78;
      sb_q.push_back(8'h78);
      tick();
      put0 = 1'b0; get0 = 1'b0;
      chk("t4_mid_fill", 32'(fc0), 32'd5);
      chk("t4_mid_data", 32'(dout0), 32'(sb_pop()));
      drain0(5, "t4_mid_drain");
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;

      // 5: 40 words through the FIFO with occupancy held between 3 and 10
      cnt = 0; nw = 0; nr = 0; cyc = 0;
      while (nr < 40 && cyc < 400) begin
         p = (nw < 40) && (cnt < 10) && (($urandom_range(0, 1) == 1) || cnt < 3);
         g = (cnt > 0) && (cnt > 3 || nw == 40) &&
             (($urandom_range(0, 1) == 1) || cnt >= 10 || nw == 40);
         put0 = p; get0 = g;
         din0 = 8'(8'h40 + nw);
         if (p) begin
            sb_q.push_back(din0);
            nw++;
         end
         tick();
         if (g) begin
            chk("t5_data", 32'(dout0), 32'(sb_pop()));
            nr++;
         end
         cnt = cnt + int'(p) - int'(g);
         chk("t5_fill", 32'(fc0), 32'(cnt));
         cyc++;
      end
      put0 = 1'b0; get0 = 1'b0;
      chk("t5_done", 32'(nr), 32'd40);
      chk("t5_err", 32'({ovf0, unf0}), 32'd0);

      // 6: FWFT instance
      rst1 = 1'b0;
      chk("t6_rst_dout", 32'(dout1), 32'd0);
      put1 = 1'b1; din1 = 8'hA5;
      tick();
      put1 = 1'b0;
      chk("t6_fwft_data", 32'(dout1), 32'hA5);
      chk("t6_fwft_empty", 32'(emp1), 32'd0);
      put1 = 1'b1; din1 = 8'h5A;
      tick();
      put1 = 1'b0;
      chk("t6_head_hold", 32'(dout1), 32'hA5);
      get1 = 1'b1;
      tick();
      get1 = 1'b0;
      chk("t6_pop_data", 32'(dout1), 32'h5A);
      put1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         din1 = 8'(8'hB0 + i);
         tick();
      end
      put1 = 1'b0;
      chk("t6_fill7", 32'(fc1), 32'd7);
      chk("t6_head7", 32'(dout1), 32'h5A);
      #2;
      rst1 = 1'b1;
      #1;
      chk("t6_async_fill", 32'(fc1), 32'd0);
      chk("t6_async_empty", 32'(emp1), 32'd1);
      chk("t6_async_dout", 32'(dout1), 32'd0);
      tick();
      rst1 = 1'b0;
      tick();
      chk("t6_post_empty", 32'(emp1), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
